// File: rtl/td4x_pkg.sv
// ============================================================================
//  Module   : td4x_pkg
//  Purpose  : Shared definitions for the TD4X core: the opcode map, the
//             control-state encoding and the ADD helper.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package td4x_pkg;

    // Instruction opcodes. Any code not listed here executes as a NOP.
    localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
    localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
    localparam logic [3:0] OP_IN_A     = 4'b0010;
    localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
    localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
    localparam logic [3:0] OP_IN_B     = 4'b0110;
    localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
    localparam logic [3:0] OP_HLT      = 4'b1000;
    localparam logic [3:0] OP_OUT_B    = 4'b1001;
    localparam logic [3:0] OP_OUT_IM   = 4'b1011;
    localparam logic [3:0] OP_JNC_IM   = 4'b1110;
    localparam logic [3:0] OP_JMP_IM   = 4'b1111;

    // Widest operand the ADD helper handles; DATA_W must stay below this.
    localparam int TD4X_MAX_W = 32;

    // Control state of the core.
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Zero-extended sum of two operands. The caller keeps bits [DATA_W:0]:
    // the low DATA_W bits are the wrapped result, bit DATA_W is the carry.
    function automatic logic [TD4X_MAX_W:0] td4x_add(
        input logic [TD4X_MAX_W-1:0] a,
        input logic [TD4X_MAX_W-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

`default_nettype wire

// File: rtl/td4x_prog_mem.sv
// ============================================================================
//  Module   : td4x_prog_mem
//  Purpose  : Program store, DEPTH words of {opcode[3:0], imm[DATA_W-1:0]}.
//             Asynchronous clear, synchronous write, combinational read.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module td4x_prog_mem #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W+3:0]   wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W+3:0]   rdata
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W+3:0] mem [DEPTH];

    // Reset wipes every word to {opcode 0, imm 0}; writes land on the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/td4x_core.sv
// ============================================================================
//  Module   : td4x_core
//  Purpose  : Parametrised TD4-style CPU with on-chip program memory, a
//             handshaked load port and a LOAD/RUN/HALT control FSM.
//  Options  : TD4X_STEP_EN adds step_en/step single-step control ports.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module td4x_core
    import td4x_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [3:0]          load_opcode,
    input  logic [DATA_W-1:0]   load_imm,
    input  logic                run_start,
    input  logic                stop,
    input  logic [DATA_W-1:0]   in_port,
    output logic [DATA_W-1:0]   out_port,
    output logic [ADDR_W-1:0]   pc_o,
    output logic                carry_o,
    output logic                halted
`ifdef TD4X_STEP_EN
   ,input  logic                step_en,
    input  logic                step
`endif
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   reg_a, reg_b, out_reg;
    logic                carry;

    logic [DATA_W+3:0]   word;
    logic [3:0]          opcode;
    logic [DATA_W-1:0]   imm;
    logic                mem_we, pc_clear, exec, step_ok;

    logic [DATA_W-1:0]   add_src;
    logic [TD4X_MAX_W:0] add_full;
    logic [DATA_W-1:0]   add_sum;
    logic                add_carry;
    logic                unused_add_hi;

`ifdef TD4X_STEP_EN
    assign step_ok = !step_en || step;
`else
    assign step_ok = 1'b1;
`endif

    td4x_prog_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (mem_we),
        .waddr  (load_addr),
        .wdata  ({load_opcode, load_imm}),
        .raddr  (pc),
        .rdata  (word)
    );

    assign opcode = word[DATA_W+3:DATA_W];
    assign imm    = word[DATA_W-1:0];

    // stop pre-empts the instruction fetched this cycle.
    assign exec = (state == ST_RUN) && !stop && step_ok;

    // One shared adder serves both ADD A,Im and ADD B,Im.
    assign add_src       = (opcode == OP_ADD_B_IM) ? reg_b : reg_a;
    assign add_full      = td4x_add(TD4X_MAX_W'(add_src), TD4X_MAX_W'(imm));
    assign add_sum       = add_full[DATA_W-1:0];
    assign add_carry     = add_full[DATA_W];
    assign unused_add_hi = ^add_full[TD4X_MAX_W:DATA_W+1];

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_LOAD;
        else        state <= state_nxt;
    end

    // Next-state decode plus the state-derived handshake and strobes.
    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        halted     = 1'b0;
        mem_we     = 1'b0;
        pc_clear   = 1'b0;
        case (state)
            ST_LOAD: begin
                load_ready = 1'b1;
                mem_we     = load_valid;
                if (run_start) begin
                    state_nxt = ST_RUN;
                    pc_clear  = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop)                              state_nxt = ST_LOAD;
                else if (exec && (opcode == OP_HLT))   state_nxt = ST_HALT;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (stop) begin
                    state_nxt = ST_LOAD;
                end else if (run_start) begin
                    state_nxt = ST_RUN;
                    pc_clear  = 1'b1;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Datapath: execute the fetched word; every non-ADD clears carry except HLT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            reg_a   <= '0;
            reg_b   <= '0;
            out_reg <= '0;
            carry   <= 1'b0;
        end else if (pc_clear) begin
            pc <= '0;
        end else if (exec) begin
            carry <= 1'b0;
            pc    <= pc + 1'b1;
            case (opcode)
                OP_ADD_A_IM: begin reg_a <= add_sum; carry <= add_carry; end
                OP_MOV_A_B:  reg_a   <= reg_b;
                OP_IN_A:     reg_a   <= in_port;
                OP_MOV_A_IM: reg_a   <= imm;
                OP_MOV_B_A:  reg_b   <= reg_a;
                OP_ADD_B_IM: begin reg_b <= add_sum; carry <= add_carry; end
                OP_IN_B:     reg_b   <= in_port;
                OP_MOV_B_IM: reg_b   <= imm;
                OP_HLT:      begin pc <= pc; carry <= carry; end
                OP_OUT_B:    out_reg <= reg_b;
                OP_OUT_IM:   out_reg <= imm;
                OP_JNC_IM:   if (!carry) pc <= imm[ADDR_W-1:0];
                OP_JMP_IM:   pc <= imm[ADDR_W-1:0];
                default:     ;
            endcase
        end
    end

    assign out_port = out_reg;
    assign pc_o     = pc;
    assign carry_o  = carry;

endmodule

`default_nettype wire

// File: tb/tb_td4x_core.sv
// ============================================================================
//  Module   : tb_td4x_core
//  Purpose  : Self-checking bench for td4x_core (DATA_W = ADDR_W = 4) with a
//             behavioural CPU model and an expected-output queue.
//  Options  : TD4X_STEP_EN exercises the single-step ports.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_td4x_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] load_addr;
    logic [3:0] load_opcode;
    logic [3:0] load_imm;
    logic       run_start;
    logic       stop;
    logic [3:0] in_port;
    logic [3:0] out_port;
    logic [3:0] pc_o;
    logic       carry_o;
    logic       halted;
    logic       step_en;
    logic       step;

    td4x_core #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_addr   (load_addr),
        .load_opcode (load_opcode),
        .load_imm    (load_imm),
        .run_start   (run_start),
        .stop        (stop),
        .in_port     (in_port),
        .out_port    (out_port),
        .pc_o        (pc_o),
        .carry_o     (carry_o),
        .halted      (halted)
`ifdef TD4X_STEP_EN
       ,.step_en     (step_en),
        .step        (step)
`endif
    );

    always #5 clk = ~clk;

    // Expected visible state after one clock edge.
    typedef struct {
        int pc;
        int out;
        int c;
        int h;
        int lr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: mode 0 = loading, 1 = running, 2 = halted.
    int m_mode, m_pc, m_a, m_b, m_out, m_c;
    int m_op[16];
    int m_im[16];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0;
        for (int i = 0; i < 16; i++) begin
            m_op[i] = 0;
            m_im[i] = 0;
        end
    endtask

    // Executes one instruction on the model following the ISA description.
    task automatic model_exec(input int inv);
        int op, im, sum, nc, npc;
        op  = m_op[m_pc];
        im  = m_im[m_pc];
        nc  = 0;
        npc = (m_pc + 1) % 16;
        case (op)
            0:  begin sum = m_a + im; m_a = sum % 16; nc = (sum > 15) ? 1 : 0; end
            1:  m_a = m_b;
            2:  m_a = inv;
            3:  m_a = im;
            4:  m_b = m_a;
            5:  begin sum = m_b + im; m_b = sum % 16; nc = (sum > 15) ? 1 : 0; end
            6:  m_b = inv;
            7:  m_b = im;
            8:  begin m_mode = 2; npc = m_pc; nc = m_c; end
            9:  m_out = m_b;
            11: m_out = im;
            14: npc = (m_c == 0) ? im : npc;
            15: npc = im;
            default: ;
        endcase
        m_c  = nc;
        m_pc = npc;
    endtask

    // Drives one cycle of inputs at the falling edge and queues the expected
    // outputs for the following rising edge.
    task automatic tick(input int lv, input int la, input int lop, input int limm,
                        input int rs, input int sp, input int st);
        exp_t e;
        int   inv;
        @(negedge clk);
        inv         = $urandom_range(0, 15);
        load_valid  = lv[0];
        load_addr   = la[3:0];
        load_opcode = lop[3:0];
        load_imm    = limm[3:0];
        run_start   = rs[0];
        stop        = sp[0];
        step        = st[0];
        in_port     = inv[3:0];
        case (m_mode)
            0: begin
                if (lv != 0) begin m_op[la] = lop; m_im[la] = limm; end
                if (rs != 0) begin m_pc = 0; m_mode = 1; end
            end
            1: begin
                if (sp != 0) m_mode = 0;
`ifdef TD4X_STEP_EN
                else if (step_en == 1'b0 || st != 0) model_exec(inv);
`else
                else model_exec(inv);
`endif
            end
            default: begin
                if (sp != 0)      m_mode = 0;
                else if (rs != 0) begin m_pc = 0; m_mode = 1; end
            end
        endcase
        e.pc  = m_pc;
        e.out = m_out;
        e.c   = m_c;
        e.h   = (m_mode == 2) ? 1 : 0;
        e.lr  = (m_mode == 0) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load_word(input int a, input int op, input int im);
        tick(1, a, op, im, 0, 0, 0);
    endtask

    // Fills the whole program store with NOPs (opcodes 10, 12, 13).
    task automatic load_nops();
        int nops[3] = '{10, 12, 13};
        for (int i = 0; i < 16; i++) load_word(i, nops[$urandom_range(0, 2)], $urandom_range(0, 15));
    endtask

    // Monitor: compare every edge for which an expectation was queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc_o",       int'(pc_o),       e.pc);
                check("out_port",   int'(out_port),   e.out);
                check("carry_o",    int'(carry_o),    e.c);
                check("halted",     int'(halted),     e.h);
                check("load_ready", int'(load_ready), e.lr);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; load_valid = 1'b0; load_addr = '0; load_opcode = '0; load_imm = '0;
        run_start = 1'b0; stop = 1'b0; in_port = '0; step_en = 1'b0; step = 1'b0;
        model_reset();
        #12;
        check("rst_load_ready", int'(load_ready), 1);
        check("rst_halted",     int'(halted),     0);
        check("rst_pc",         int'(pc_o),       0);
        check("rst_out",        int'(out_port),   0);
        check("rst_carry",      int'(carry_o),    0);
        rst_n = 1'b1;

        // Load and run: MOV A,3; ADD A,2; MOV B,A; OUT B; HLT.
        load_word(0, 3, 3);
        load_word(1, 0, 2);
        load_word(2, 4, 0);
        load_word(3, 9, 0);
        load_word(4, 8, 0);
        tick(0, 0, 0, 0, 1, 0, 0);
        idle(6);
        @(posedge clk); #2;
        check("prog1_out",    int'(out_port), 5);
        check("prog1_pc",     int'(pc_o),     4);
        check("prog1_halted", int'(halted),   1);

        // Overflow and JNC: MOV A,1; ADD A,15 (carry); JNC 0 not taken; OUT 7; HLT.
        tick(0, 0, 0, 0, 0, 1, 0);
        load_nops();
        load_word(0, 3, 1);
        load_word(1, 0, 15);
        load_word(2, 14, 0);
        load_word(3, 11, 7);
        load_word(4, 8, 0);
        tick(0, 0, 0, 0, 1, 0, 0);
        idle(7);
        @(posedge clk); #2;
        check("jnc_out", int'(out_port), 7);
        check("jnc_pc",  int'(pc_o),     4);

        // PC wrap over a program of NOPs.
        tick(0, 0, 0, 0, 0, 1, 0);
        load_nops();
        tick(0, 0, 0, 0, 1, 0, 0);
        idle(17);
        @(posedge clk); #2;
        check("wrap_pc", int'(pc_o), 1);
        tick(0, 0, 0, 0, 0, 1, 0);

        // Write to address 0 and start in the same cycle.
        tick(1, 0, 11, 9, 1, 0, 0);
        idle(1);
        @(posedge clk); #2;
        check("wr_start_out", int'(out_port), 9);
        idle(3);
        tick(0, 0, 0, 0, 0, 1, 0);
        @(posedge clk); #2;
        check("stop_load_ready", int'(load_ready), 1);

        // Asynchronous reset between edges clears everything at once.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_out",        int'(out_port),   0);
        check("arst_pc",         int'(pc_o),       0);
        check("arst_carry",      int'(carry_o),    0);
        check("arst_halted",     int'(halted),     0);
        check("arst_load_ready", int'(load_ready), 1);
        model_reset();
        rst_n = 1'b1;
        // The cleared store now holds ADD A,0 everywhere, so OUT stays 0.
        tick(0, 0, 0, 0, 1, 0, 0);
        idle(5);
        @(posedge clk); #2;
        check("cleared_mem_out", int'(out_port), 0);

        // Randomised programs and control traffic.
        tick(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) load_word(i, $urandom_range(0, 15), $urandom_range(0, 15));
        tick(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15),
                 ($urandom_range(0, 14) == 0) ? 1 : 0,
                 ($urandom_range(0, 24) == 0) ? 1 : 0, 0);
        end

`ifdef TD4X_STEP_EN
        // Single step: no pulses hold pc, three pulses advance it by three.
        tick(0, 0, 0, 0, 0, 1, 0);
        load_nops();
        tick(0, 0, 0, 0, 1, 0, 0);
        step_en = 1'b1;
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        check("step_hold_pc", int'(pc_o), 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #2;
        check("step_pc", int'(pc_o), 3);
        step_en = 1'b0;
        idle(2);
`endif

        idle(2);
        @(posedge clk); #3;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
